// File: rtl/alu_mult_seq_pkg.sv
// Shared definitions for the shift-and-add multiplier sequencer.
// Holds the ALU opcode map and the sequencer state encoding.
package alu_mult_seq_pkg;

    localparam logic [2:0] OP_RLL = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_AND = 3'b111;

    // 2'b11 is unused and recovers to S_IDLE
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/mult_seq_fsm.sv
// Sequencer control: state register and iteration counter.
// RUN always lasts exactly N cycles, then a single DONE cycle.
module mult_seq_fsm
    import alu_mult_seq_pkg::*;
#(
    parameter int unsigned N  = 16,
    parameter int unsigned CW = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    output state_e state
);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                cnt_d = CW'(cnt_q + 1'b1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/alu_mult_seq.sv
// Unsigned shift-and-add multiplier that borrows the execute-stage ALU adder.
// Yields the low N product bits plus an unsigned overflow flag.
module alu_mult_seq
    import alu_mult_seq_pkg::*;
#(
    parameter int unsigned N  = 16,
    parameter int unsigned CW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] opA,
    input  logic [N-1:0] opB,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] product,
    output logic         ovf,
    output logic [N-1:0] alu_A,
    output logic [N-1:0] alu_B,
    output logic         alu_Cin,
    output logic [2:0]   alu_Op,
    output logic         alu_invA,
    output logic         alu_invB,
    output logic         alu_sign,
    input  logic [N-1:0] alu_Out,
    input  logic         alu_Ofl
);

    state_e        state;
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  mcand_q, mcand_d;
    logic [N-1:0]  mplier_q, mplier_d;
    logic          ovf_q, ovf_d;
    logic          lost_q, lost_d;

    mult_seq_fsm #(
        .N  (N),
        .CW (CW)
    ) u_fsm (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .state (state)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            ovf_q    <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            ovf_q    <= ovf_d;
            lost_q   <= lost_d;
        end
    end

    // lost records a set multiplicand bit already shifted out; any later add is then an overflow
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        ovf_d    = ovf_q;
        lost_d   = lost_q;
        if (state == S_IDLE && start) begin
            acc_d    = '0;
            mcand_d  = opA;
            mplier_d = opB;
            ovf_d    = 1'b0;
            lost_d   = 1'b0;
        end else if (state == S_RUN) begin
            if (mplier_q[0]) begin
                acc_d = alu_Out;
                ovf_d = ovf_q | alu_Ofl | lost_q;
            end
            lost_d   = lost_q | mcand_q[N-1];
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    assign busy    = (state == S_RUN);
    assign done    = (state == S_DONE);
    assign product = acc_q;
    assign ovf     = ovf_q;

    assign alu_A    = acc_q;
    assign alu_B    = mcand_q;
    assign alu_Cin  = 1'b0;
    assign alu_Op   = OP_ADD;
    assign alu_invA = 1'b0;
    assign alu_invB = 1'b0;
    assign alu_sign = 1'b0;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed bench for alu_mult_seq with an unsigned-add ALU stand-in.
module tb_alu_mult_seq;

    localparam int unsigned N = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] opA, opB;
    logic         busy, done, ovf;
    logic [N-1:0] product;
    logic [N-1:0] alu_A, alu_B, alu_Out;
    logic         alu_Cin, alu_invA, alu_invB, alu_sign, alu_Ofl;
    logic [2:0]   alu_Op;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // ALU in unsigned add mode: Ofl is the carry-out
    assign {alu_Ofl, alu_Out} = {1'b0, alu_A} + {1'b0, alu_B} + {{N{1'b0}}, alu_Cin};

    alu_mult_seq #(.N(N), .CW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .opA      (opA),
        .opB      (opB),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .ovf      (ovf),
        .alu_A    (alu_A),
        .alu_B    (alu_B),
        .alu_Cin  (alu_Cin),
        .alu_Op   (alu_Op),
        .alu_invA (alu_invA),
        .alu_invB (alu_invB),
        .alu_sign (alu_sign),
        .alu_Out  (alu_Out),
        .alu_Ofl  (alu_Ofl)
    );

    // Start at one edge, then check busy for N cycles, done on cycle N+1, idle after
    task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] exp_p, input logic exp_o);
        @(negedge clk);
        opA = a; opB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (product !== 16'h0000) begin
            n_bad++;
            $display("FAIL %s acc_clear: product=%h want 0000", name, product);
        end
        for (int i = 1; i <= int'(N); i++) begin
            n_cmp++;
            if ({busy, done} !== 2'b10) begin
                n_bad++;
                $display("FAIL %s run_cycle%0d: busy,done=%b want 10", name, i, {busy, done});
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({busy, done} !== 2'b01) begin
            n_bad++;
            $display("FAIL %s done_cycle: busy,done=%b want 01", name, {busy, done});
        end
        n_cmp++;
        if (product !== exp_p) begin
            n_bad++;
            $display("FAIL %s product: got %h want %h", name, product, exp_p);
        end
        n_cmp++;
        if (ovf !== exp_o) begin
            n_bad++;
            $display("FAIL %s ovf: got %b want %b", name, ovf, exp_o);
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, done, product} !== {2'b00, exp_p}) begin
            n_bad++;
            $display("FAIL %s after_done: busy,done=%b product=%h want 00 %h",
                     name, {busy, done}, product, exp_p);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; opA = '0; opB = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, ovf, product} !== 19'h0) begin
            n_bad++;
            $display("FAIL reset: busy,done,ovf,product=%h want 0", {busy, done, ovf, product});
        end
    endtask

    task automatic test_alu_ctrl();
        n_cmp++;
        if ({alu_Cin, alu_Op, alu_invA, alu_invB, alu_sign} !== 7'b0_100_000) begin
            n_bad++;
            $display("FAIL alu_ctrl: got %b want 0100000",
                     {alu_Cin, alu_Op, alu_invA, alu_invB, alu_sign});
        end
    endtask

    task automatic test_basic();
        run_op("3x5", 16'h0003, 16'h0005, 16'h000F, 1'b0);
        run_op("ffffx1", 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0);
        run_op("ffffxffff", 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1);
    endtask

    task automatic test_lost_path();
        run_op("8000x2", 16'h8000, 16'h0002, 16'h0000, 1'b1);
        run_op("0100x0100", 16'h0100, 16'h0100, 16'h0000, 1'b1);
    endtask

    task automatic test_zero_signed();
        run_op("1234x0", 16'h1234, 16'h0000, 16'h0000, 1'b0);
        run_op("0x1234", 16'h0000, 16'h1234, 16'h0000, 1'b0);
        run_op("neg2x3", 16'hFFFE, 16'h0003, 16'hFFFA, 1'b1);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        opA = 16'h0007; opB = 16'h0009; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= int'(N); i++) begin
            if (i == 5) begin
                opA = 16'h0002; opB = 16'h0002; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            n_cmp++;
            if ({busy, done} !== 2'b10) begin
                n_bad++;
                $display("FAIL b2b run_cycle%0d: busy,done=%b want 10", i, {busy, done});
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({busy, done, ovf, product} !== {3'b010, 16'h003F}) begin
            n_bad++;
            $display("FAIL b2b done: busy,done,ovf=%b product=%h want 010 003f",
                     {busy, done, ovf}, product);
        end
        // start offered during DONE must not launch a new operation
        opA = 16'h0005; opB = 16'h0005; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if ({busy, done, product} !== {2'b00, 16'h003F}) begin
            n_bad++;
            $display("FAIL start_in_done: busy,done=%b product=%h want 00 003f",
                     {busy, done}, product);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL start_in_done_late: busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_abort();
        logic saw_done;
        saw_done = 1'b0;
        @(negedge clk);
        opA = 16'h00FF; opB = 16'h00FF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, ovf, product} !== 19'h0) begin
            n_bad++;
            $display("FAIL reset_abort: busy,done,ovf,product=%h want 0", {busy, done, ovf, product});
        end
        for (int i = 0; i < int'(N) + 2; i++) begin
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_abort_quiet: activity=%b want 0", saw_done);
        end
        run_op("ffxff", 16'h00FF, 16'h00FF, 16'hFE01, 1'b0);
    endtask

    initial begin
        test_reset();
        test_alu_ctrl();
        test_basic();
        test_lost_path();
        test_zero_signed();
        test_back_to_back();
        test_reset_abort();
        test_alu_ctrl();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
